core_run_monitor: RTL and testbench
===================================

Name: core_run_monitor

Overview:
- Synthesizable run controller and monitor for rv32i_core; replaces the fixed reset pulse and fixed run time in the core testbench.
- Sequences core reset, then watches pipeline observation ports for halt conditions: ecall/ebreak in IF/ID, PC self-loop, or cycle timeout.
- Counts per-channel pipeline events with saturating counters and freezes all results on completion, for bench or FPGA readback.

Parameters:
- XLEN, 32, width of pc and instruction ports
- CNT_W, 32, width of cycle counter and each event counter
- NUM_EVT, 4, number of event counter channels
- RST_HOLD, 2, cycles core_rst is held high after start (min 1)
- MAX_CYCLES, 100, RUN-state cycle budget before timeout (min 1)
- LOOP_REPEAT, 8, consecutive unchanged-PC cycles that count as a self-loop halt (min 2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; accepted only in IDLE
- abort  in  1  pulse; returns to IDLE from RESET, RUN or DONE
- clear  in  1  pulse; DONE -> IDLE, clears status and counters
- pc  in  XLEN  core fetch PC
- pc_en  in  1  core PC update enable
- if_id_instr  in  XLEN  instruction in IF/ID
- if_id_flush  in  1  IF/ID flush; the instruction in IF/ID is invalid this cycle
- evt_in  in  NUM_EVT  event strobes, e.g. branch_ex, branch_taken_ex, load_stall, id_ex_flush
- core_rst  out  1  active-high reset to the core
- running  out  1  high in RUN
- done  out  1  high in DONE
- done_code  out  3  0 none, 1 ecall, 2 ebreak, 3 self-loop, 4 timeout
- cycle_cnt  out  CNT_W  RUN cycles elapsed
- halt_pc  out  XLEN  pc captured on the halt cycle
- evt_cnt  out  NUM_EVT*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - core_rst=1; running=0; done=0; done_code=0.
  - cycle_cnt, halt_pc, all evt_cnt and the internal loop counter go to 0.
- States: IDLE, RESET, RUN, DONE. All outputs are registered.
- IDLE:
  - core_rst=1.
  - start moves to RESET and zeroes cycle_cnt, evt_cnt, halt_pc, done_code and the loop counter.
- RESET:
  - core_rst=1 for exactly RST_HOLD cycles, then RUN.
  - The first RUN cycle has core_rst=0.
- RUN:
  - core_rst=0; running=1; cycle_cnt increments every cycle.
  - evt_cnt[i] increments when evt_in[i]=1. Each counter saturates at all-ones and never wraps.
- Halt checks, evaluated each RUN cycle on current inputs:
  - ecall: if_id_instr==32'h00000073 and !if_id_flush.
  - ebreak: if_id_instr==32'h00100073 and !if_id_flush.
  - Self-loop: loop counter increments when pc_en=1 and pc equals the previous cycle's pc; otherwise it resets to 0. Halt when the counter reaches LOOP_REPEAT-1.
  - Timeout: cycle_cnt==MAX_CYCLES-1.
- Simultaneous halts: priority is ecall > ebreak > self-loop > timeout. One code is recorded.
- On a halt, in the next cycle:
  - State is DONE; done=1; running=0; core_rst=1 (core frozen).
  - done_code is set; halt_pc holds the pc from the halt cycle.
  - cycle_cnt includes the halt cycle.
  - Events present on the halt cycle are counted.
- DONE:
  - All counters and status are frozen.
  - clear moves to IDLE and zeroes all status and counters.
  - start is ignored.
- abort in RESET, RUN or DONE moves to IDLE next cycle. Counters hold their values (not cleared). done_code=0.
- abort and clear together in DONE: abort wins; counters hold.
- start together with abort in IDLE: start wins.
- rst_n asserted mid-run: immediate IDLE with core_rst=1, regardless of the clock.

Test Plan:
- Release rst_n, pulse start, pc increments by 4 each cycle, no halt -> core_rst high for 2 cycles; done=1 after 100 RUN cycles; done_code=4; cycle_cnt=100.
- Drive if_id_instr=32'h00000073 on RUN cycle 10 -> done next cycle; done_code=1; cycle_cnt=11; halt_pc equals pc on that cycle.
- Present ecall with if_id_flush=1, then ebreak on the same cycle as the timeout -> ecall ignored; done_code=2 (ebreak beats timeout).
- Hold pc=32'h00000040 with pc_en=1 from RUN cycle 20 -> done_code=3 on cycle 27 (8 equal samples including the first); halt_pc=32'h40.
- Use CNT_W=4 and hold evt_in[0]=1 for 30 cycles -> evt_cnt[0] reads 4'hF; evt_in[1] toggling every other cycle counts exactly half.
- Pulse abort mid-RUN, then clear in DONE; separately drop rst_n mid-RUN -> IDLE, core_rst=1, done_code=0 in each case; clear zeroes counters, and rst_n takes effect asynchronously.

Source files
------------

// File: rtl/core_run_monitor.sv
// Run controller for rv32i_core: sequences core reset, watches for ecall/ebreak/self-loop/timeout,
// counts pipeline events with saturating counters and freezes everything once the run completes.
module core_run_monitor #(
   parameter int XLEN        = 32,
   parameter int CNT_W       = 32,
   parameter int NUM_EVT     = 4,
   parameter int RST_HOLD    = 2,
   parameter int MAX_CYCLES  = 100,
   parameter int LOOP_REPEAT = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     clear,
   input  logic [XLEN-1:0]          pc,
   input  logic                     pc_en,
   input  logic [XLEN-1:0]          if_id_instr,
   input  logic                     if_id_flush,
   input  logic [NUM_EVT-1:0]       evt_in,
   output logic                     core_rst,
   output logic                     running,
   output logic                     done,
   output logic [2:0]               done_code,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [XLEN-1:0]          halt_pc,
   output logic [NUM_EVT*CNT_W-1:0] evt_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_t;

   localparam logic [2:0] CODE_ECALL   = 3'd1;
   localparam logic [2:0] CODE_EBREAK  = 3'd2;
   localparam logic [2:0] CODE_LOOP    = 3'd3;
   localparam logic [2:0] CODE_TIMEOUT = 3'd4;

   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam int LOOP_W = $clog2(LOOP_REPEAT + 1);
   // Wide enough for both the counter and the cycle budget, so a narrow counter never aliases the limit.
   localparam int TMO_W  = (CNT_W > 32) ? CNT_W : 32;

   state_t            state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [LOOP_W-1:0] loop_cnt;
   logic [XLEN-1:0]   prev_pc;

   logic       is_ecall, is_ebreak, pc_same, loop_hit, timeout_hit, halt;
   logic [2:0] halt_code;

   always_comb begin
      is_ecall    = !if_id_flush && (if_id_instr == XLEN'(32'h0000_0073));
      is_ebreak   = !if_id_flush && (if_id_instr == XLEN'(32'h0010_0073));
      pc_same     = pc_en && (pc == prev_pc);
      loop_hit    = pc_same && (loop_cnt == LOOP_W'(LOOP_REPEAT - 2));
      timeout_hit = (TMO_W'(cycle_cnt) == TMO_W'(MAX_CYCLES - 1));
      halt_code   = 3'd0;
      if (is_ecall)         halt_code = CODE_ECALL;
      else if (is_ebreak)   halt_code = CODE_EBREAK;
      else if (loop_hit)    halt_code = CODE_LOOP;
      else if (timeout_hit) halt_code = CODE_TIMEOUT;
      halt = (halt_code != 3'd0);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_RESET;
         S_RESET: begin
            if (abort)                                  state_nxt = S_IDLE;
            else if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (abort)     state_nxt = S_IDLE;
            else if (halt) state_nxt = S_DONE;
         end
         S_DONE:  if (abort || clear) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         core_rst <= 1'b1;
         running  <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nxt;
         core_rst <= (state_nxt != S_RUN);
         running  <= (state_nxt == S_RUN);
         done     <= (state_nxt == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         loop_cnt  <= '0;
         prev_pc   <= '0;
         done_code <= 3'd0;
         cycle_cnt <= '0;
         halt_pc   <= '0;
         evt_cnt   <= '0;
      end else begin
         prev_pc <= pc;
         case (state)
            S_IDLE: begin
               if (start) begin
                  hold_cnt  <= '0;
                  loop_cnt  <= '0;
                  done_code <= 3'd0;
                  cycle_cnt <= '0;
                  halt_pc   <= '0;
                  evt_cnt   <= '0;
               end
            end
            S_RESET: hold_cnt <= hold_cnt + 1'b1;
            S_RUN: begin
               // Abort leaves the counters exactly as they were before this cycle.
               if (abort) begin
                  done_code <= 3'd0;
               end else begin
                  if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
                  loop_cnt <= pc_same ? loop_cnt + 1'b1 : '0;
                  for (int i = 0; i < NUM_EVT; i++) begin
                     if (evt_in[i] && (evt_cnt[i*CNT_W +: CNT_W] != '1))
                        evt_cnt[i*CNT_W +: CNT_W] <= evt_cnt[i*CNT_W +: CNT_W] + 1'b1;
                  end
                  if (halt) begin
                     done_code <= halt_code;
                     halt_pc   <= pc;
                  end
               end
            end
            S_DONE: begin
               if (abort) begin
                  done_code <= 3'd0;
               end else if (clear) begin
                  loop_cnt  <= '0;
                  done_code <= 3'd0;
                  cycle_cnt <= '0;
                  halt_pc   <= '0;
                  evt_cnt   <= '0;
               end
            end
            default: hold_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: directed and randomized runs scored against a vector-scan reference model.
module tb_core_run_monitor;
   localparam int MAXC = 100;
   localparam int LR   = 8;
   localparam int NV   = 128;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, start, abort, clear, pc_en, if_id_flush;
   logic [31:0]  pc, if_id_instr;
   logic [3:0]   evt_in;
   logic         core_rst, running, done;
   logic [2:0]   done_code;
   logic [31:0]  cycle_cnt, halt_pc;
   logic [127:0] evt_cnt;

   logic         start_b, abort_b, clear_b;
   logic [3:0]   evt_b;
   logic         core_rst_b, running_b, done_b;
   logic [2:0]   done_code_b;
   logic [3:0]   cycle_cnt_b;
   logic [31:0]  halt_pc_b;
   logic [15:0]  evt_cnt_b;

   core_run_monitor dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .clear(clear),
      .pc(pc), .pc_en(pc_en), .if_id_instr(if_id_instr), .if_id_flush(if_id_flush),
      .evt_in(evt_in), .core_rst(core_rst), .running(running), .done(done),
      .done_code(done_code), .cycle_cnt(cycle_cnt), .halt_pc(halt_pc), .evt_cnt(evt_cnt)
   );

   core_run_monitor #(.CNT_W(4)) dut_narrow (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .clear(clear_b),
      .pc(pc), .pc_en(pc_en), .if_id_instr(if_id_instr), .if_id_flush(if_id_flush),
      .evt_in(evt_b), .core_rst(core_rst_b), .running(running_b), .done(done_b),
      .done_code(done_code_b), .cycle_cnt(cycle_cnt_b), .halt_pc(halt_pc_b), .evt_cnt(evt_cnt_b)
   );

   int checks   = 0;
   int failures = 0;

   // Per-RUN-cycle stimulus vectors; index k is RUN cycle k.
   logic [31:0] v_pc[NV];
   logic        v_en[NV];
   logic [31:0] v_instr[NV];
   logic        v_flush[NV];
   logic [3:0]  v_evt[NV];
   logic [31:0] pre_pc;
   int          exp_k;
   logic [2:0]  exp_code;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pc_before(input int j);
      if (j == 0) return pre_pc;
      return v_pc[j-1];
   endfunction

   // First RUN cycle on which any halt rule fires, and which rule wins.
   task automatic model();
      exp_k = -1;
      exp_code = 3'd0;
      for (int k = 0; k < NV && exp_k < 0; k++) begin
         int run = 0;
         logic [2:0] code = 3'd0;
         for (int j = k; j >= 0; j--) begin
            if (v_en[j] && v_pc[j] == pc_before(j)) run++;
            else break;
         end
         if (v_instr[k] == ECALL && !v_flush[k])       code = 3'd1;
         else if (v_instr[k] == EBREAK && !v_flush[k]) code = 3'd2;
         else if (run >= LR - 1)                       code = 3'd3;
         else if (k == MAXC - 1)                       code = 3'd4;
         if (code != 3'd0) begin
            exp_k = k;
            exp_code = code;
         end
      end
   endtask

   function automatic logic [31:0] evt_exp(input int c, input int last, input int cw);
      longint s   = 0;
      longint sat = (longint'(1) << cw) - 1;
      for (int j = 0; j <= last; j++) s += longint'(v_evt[j][c]);
      if (s > sat) s = sat;
      return s[31:0];
   endfunction

   task automatic gen_base();
      logic [31:0] r;
      pre_pc = 32'h0000_FFF0;
      for (int k = 0; k < NV; k++) begin
         r = $urandom;
         r[6:0] = 7'h33;
         v_pc[k]    = 32'h0000_1000 + 32'(k * 4);
         v_en[k]    = 1'b1;
         v_instr[k] = r;
         v_flush[k] = ($urandom_range(0, 3) == 0);
         v_evt[k]   = 4'($urandom);
      end
   endtask

   task automatic gen_random();
      logic [31:0] r, p;
      int stay, sel;
      stay   = $urandom_range(30, 85);
      p      = 32'h0000_2000;
      pre_pc = ($urandom_range(0, 1) == 1) ? p : 32'h0000_1FFC;
      for (int k = 0; k < NV; k++) begin
         if ($urandom_range(0, 99) >= stay) p = p + 32'd4;
         r = $urandom;
         r[6:0] = 7'h33;
         sel = $urandom_range(0, 99);
         v_pc[k]    = p;
         v_en[k]    = ($urandom_range(0, 9) != 0);
         v_instr[k] = (sel < 2) ? ECALL : (sel < 4) ? EBREAK : r;
         v_flush[k] = ($urandom_range(0, 3) == 0);
         v_evt[k]   = 4'($urandom);
      end
   endtask

   task automatic check_evts(input string tag, input int last);
      for (int c = 0; c < 4; c++)
         check($sformatf("%s.evt%0d", tag, c), evt_cnt[c*32 +: 32], evt_exp(c, last, 32));
   endtask

   task automatic run_a(input string tag, input int abort_at, input int rst_at, input logic with_abort);
      int k;
      logic halted;
      model();
      pc = pre_pc; pc_en = 1'b1; if_id_instr = 32'h33; if_id_flush = 1'b0; evt_in = 4'hF;
      start = 1'b1; abort = with_abort;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check({tag, ".rst0"}, {core_rst, running, done, done_code}, 6'b100_000);
      check({tag, ".zeroed"}, cycle_cnt, 32'd0);
      @(posedge clk); #1;
      check({tag, ".rst1"}, {core_rst, running}, 2'b10);
      @(posedge clk); #1;
      check({tag, ".run0"}, {core_rst, running}, 2'b01);
      k = 0;
      halted = 1'b0;
      while (k < NV) begin
         pc = v_pc[k]; pc_en = v_en[k]; if_id_instr = v_instr[k];
         if_id_flush = v_flush[k]; evt_in = v_evt[k];
         abort = (k == abort_at);
         if (k == rst_at) begin
            #2 rst_n = 1'b0;
            #1;
            check({tag, ".async_flags"}, {core_rst, running, done, done_code}, 6'b100_000);
            check({tag, ".async_cnt"}, cycle_cnt, 32'd0);
            check({tag, ".async_evt"}, evt_cnt[63:0], 64'd0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            return;
         end
         @(posedge clk); #1;
         abort = 1'b0;
         if (k == abort_at) begin
            check({tag, ".abort_flags"}, {core_rst, running, done, done_code}, 6'b100_000);
            check({tag, ".abort_cnt"}, cycle_cnt, 32'(abort_at));
            check_evts({tag, ".abort"}, abort_at - 1);
            return;
         end
         if (done) begin
            halted = 1'b1;
            break;
         end
         k++;
      end
      check({tag, ".halted"}, halted, 1'b1);
      check({tag, ".halt_cycle"}, k, exp_k);
      check({tag, ".flags"}, {core_rst, running, done}, 3'b101);
      check({tag, ".code"}, done_code, exp_code);
      check({tag, ".cycles"}, cycle_cnt, 32'(exp_k + 1));
      check({tag, ".halt_pc"}, halt_pc, v_pc[exp_k]);
      check_evts(tag, exp_k);
   endtask

   task automatic do_clear(input string tag);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      check({tag, ".clr_flags"}, {core_rst, running, done, done_code}, 6'b100_000);
      check({tag, ".clr_cnt"}, cycle_cnt, 32'd0);
      check({tag, ".clr_pc"}, halt_pc, 32'd0);
      check({tag, ".clr_evt_lo"}, evt_cnt[63:0], 64'd0);
      check({tag, ".clr_evt_hi"}, evt_cnt[127:64], 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; clear = 1'b0;
      start_b = 1'b0; abort_b = 1'b0; clear_b = 1'b0; evt_b = 4'd0;
      pc = 32'd0; pc_en = 1'b0; if_id_instr = 32'h33; if_id_flush = 1'b0; evt_in = 4'd0;
      #12;
      check("reset.flags", {core_rst, running, done, done_code}, 6'b100_000);
      check("reset.cnt", cycle_cnt, 32'd0);
      check("reset.pc", halt_pc, 32'd0);
      check("reset.evt", evt_cnt[63:0], 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Timeout after the full budget, then start must be ignored in DONE.
      gen_base();
      run_a("timeout", -1, -1, 1'b0);
      check("timeout.code_const", done_code, 3'd4);
      check("timeout.cnt_const", cycle_cnt, 32'd100);
      start = 1'b1; evt_in = 4'hF;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("done.start_ignored", {done, done_code}, 4'b1_100);
      check("done.frozen_cnt", cycle_cnt, 32'd100);
      check("done.frozen_evt0", evt_cnt[31:0], evt_exp(0, 99, 32));
      do_clear("timeout");

      // ecall on RUN cycle 10; start and abort together in IDLE.
      gen_base();
      v_instr[10] = ECALL; v_flush[10] = 1'b0;
      run_a("ecall", -1, -1, 1'b1);
      check("ecall.code_const", done_code, 3'd1);
      check("ecall.cnt_const", cycle_cnt, 32'd11);
      do_clear("ecall");

      // Flushed ecall ignored; ebreak on the timeout cycle wins.
      gen_base();
      v_instr[50] = ECALL;  v_flush[50] = 1'b1;
      v_instr[99] = EBREAK; v_flush[99] = 1'b0;
      run_a("ebreak", -1, -1, 1'b0);
      check("ebreak.code_const", done_code, 3'd2);
      do_clear("ebreak");

      // Self-loop at pc 0x40 from RUN cycle 20; then abort+clear together in DONE.
      gen_base();
      for (int k = 20; k < NV; k++) begin
         v_pc[k] = 32'h40; v_en[k] = 1'b1;
      end
      run_a("loop", -1, -1, 1'b0);
      check("loop.code_const", done_code, 3'd3);
      check("loop.halt_cycle_const", exp_k, 27);
      check("loop.pc_const", halt_pc, 32'h40);
      abort = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0; clear = 1'b0;
      check("abortclr.flags", {core_rst, running, done, done_code}, 6'b100_000);
      check("abortclr.cnt_held", cycle_cnt, 32'd28);
      check("abortclr.pc_held", halt_pc, 32'h40);

      // Abort mid-RUN: counters hold, next start clears them.
      gen_base();
      run_a("abort", 40, -1, 1'b0);

      // Asynchronous reset mid-RUN.
      gen_base();
      run_a("arst", -1, 30, 1'b0);

      for (int n = 0; n < 6; n++) begin
         gen_random();
         run_a($sformatf("rand%0d", n), -1, -1, 1'b0);
         do_clear($sformatf("rand%0d", n));
      end

      // Narrow counters: saturation on a held strobe, exact count on a toggling one.
      pc = 32'hFFF0; pc_en = 1'b1; if_id_instr = 32'h33; if_id_flush = 1'b0;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("narrow.run0", {core_rst_b, running_b}, 2'b01);
      for (int k = 0; k < 30; k++) begin
         pc = 32'h3000 + 32'(k * 4);
         if_id_instr = (k == 29) ? ECALL : 32'h33;
         evt_b = {2'b00, (k % 2 == 1) && (k < 28), 1'b1};
         @(posedge clk); #1;
      end
      evt_b = 4'd0; if_id_instr = 32'h33;
      check("narrow.flags", {core_rst_b, running_b, done_b, done_code_b}, 6'b101_001);
      check("narrow.cnt_sat", cycle_cnt_b, 4'hF);
      check("narrow.evt0_sat", evt_cnt_b[3:0], 4'hF);
      check("narrow.evt1_half", evt_cnt_b[7:4], 4'hE);
      check("narrow.evt_rest", evt_cnt_b[15:8], 8'h00);
      check("narrow.halt_pc", halt_pc_b, 32'h3074);
      abort_b = 1'b1;
      @(posedge clk); #1;
      abort_b = 1'b0;
      check("narrow.abort", {core_rst_b, done_b, done_code_b}, 5'b10_000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
